muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle multiply/divide unit for the pipelined core; owns the HI/LO register pair.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage.
//  Runs one radix-2 shift-add (mul) or restoring-subtract (div) step per cycle.
//  Drives a stall to the hazard unit while a result is pending.
//  The single-cycle ALU keeps MUL; MFHI/MFLO read hi/lo from this block.
// PARAMETERS
//  W   32  operand width; HI and LO are each W bits
//  CW  6   iteration counter width, >= clog2(W+1)
// PORTS
//  clk     in   1    rising-edge clock, single domain
//  reset   in   1    synchronous, active-high
//  start   in   1    op valid in EX this cycle
//  op      in   3    000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//  srcA    in   W    multiplicand/dividend/MT data
//  srcB    in   W    multiplier/divisor
//  rd_req  in   1    MFHI/MFLO in EX this cycle
//  stall   out  1    freeze IF/ID/EX
//  busy    out  1    iterative op in flight
//  done    out  1    1-cycle pulse; hi/lo take final values at this edge
//  hi      out  W    HI register
//  lo      out  W    LO register
// BEHAVIOUR
//  - Reset (sync, any state incl. mid-op): state=IDLE, hi=lo=0, busy=done=stall=0, counter=0.
//  - FSM IDLE -> RUN -> FIX -> IDLE.
//    IDLE: start & op in {MULT,MULTU,DIV,DIVU} -> RUN. Latch |srcA|,|srcB|, result signs, counter=0.
//    RUN: one step per cycle; counter==W-1 -> FIX.
//    FIX: apply sign fix-up, write hi/lo, done=1 -> IDLE.
//  - Latency: start sampled at edge k. busy=1 for cycles k+1..k+W+1; done=1 in cycle k+W+1.
//    Results visible and busy=0 from cycle k+W+2.
//  - MTHI/MTLO in IDLE: hi or lo <= srcA at the same edge. No busy, no stall.
//  - Ops 110/111 are ignored; no state change.
//  - stall = busy & (start | rd_req). A start or read arriving during busy is not accepted.
//    It is held by the pipeline freeze and accepted on the first cycle busy=0.
//  - start while busy (incl. the FIX cycle) never restarts or corrupts the op in flight.
//  - MULT/MULTU: {hi,lo} = full 2W-bit product.
//    MULT sign: product negated iff srcA[W-1]^srcB[W-1].
//  - DIV/DIVU: lo=quotient, hi=remainder. DIV truncates toward zero.
//    Quotient negated iff signs differ; remainder takes the dividend's sign.
//  - Divide by zero (srcB==0): full latency still taken; hi=srcA, lo={W{1'b1}}.
//    No exception raised.
//  - Signed edge case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
//  - Magnitude of the most-negative operand is handled as a W-bit unsigned value 2^(W-1); no overflow.
//  - hi/lo hold their old values throughout RUN and update only at the FIX edge.
//    rd_req during RUN therefore stalls; it never returns a partial value.
// STRUCTURE
//  - Shared package/header muldiv_defs: op encodings (OP_MULT..OP_MTLO),
//    state encodings (S_IDLE, S_RUN, S_FIX), default W.
//  - Sub-module muldiv_sign_fix: combinational. Takes raw {hi,lo}, sign flags and op class;
//    returns the signed-corrected {hi,lo}. Instantiated once, for the FIX cycle.
//  - Top level holds the FSM, counter, 2W-bit accumulator/remainder shift register and W-bit adder/subtractor.
// TESTING
//  1 MULT srcA=-3, srcB=5 -> done in cycle k+33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  2 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  3 DIVU 100/7 -> lo=14, hi=2.
//    DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    DIV by 0 with srcA=9 -> hi=9, lo=0xFFFFFFFF.
//  4 rd_req held high from k+1 -> stall=1 through cycle k+33, stall=0 at k+34.
//    A second start during RUN is ignored; the first result is intact.
//  5 reset asserted in RUN cycle 10 -> next cycle busy=0, hi=lo=0, state IDLE.
//    A new MULT 2*3 then gives lo=6.
//  6 MTLO srcA=0x1234 -> lo=0x1234 next cycle, busy/stall stay 0.
//    MTHI during busy is not accepted (stall=1); it completes after done.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op and state encodings, default widths.
package muldiv_sequencer_pkg;

    localparam int unsigned W_DEFAULT  = 32;
    localparam int unsigned CW_DEFAULT = 6;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    typedef enum logic {
        CLS_MUL,
        CLS_DIV
    } opclass_e;

    // MULT/MULTU/DIV/DIVU all have op[2]==0; they are the iterative ops.
    function automatic logic is_iter(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
interface muldiv_sequencer_if #(
    parameter int unsigned W = muldiv_sequencer_pkg::W_DEFAULT
);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         rd_req;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, srcA, srcB, rd_req,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, rd_req,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer_sign_fix.sv
// Combinational sign correction of the unsigned magnitude result produced by the iterative core.
module muldiv_sequencer_sign_fix
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic [2*W-1:0] raw,
    input  opclass_e       cls,
    input  logic           neg_q,
    input  logic           neg_r,
    output logic [W-1:0]   hi,
    output logic [W-1:0]   lo
);

    logic [2*W-1:0] prod_neg;
    logic [W-1:0]   rem_raw;
    logic [W-1:0]   quo_raw;

    always_comb begin
        prod_neg = -raw;
        rem_raw  = raw[2*W-1:W];
        quo_raw  = raw[W-1:0];
        if (cls == CLS_MUL) begin
            {hi, lo} = neg_q ? prod_neg : raw;
        end else begin
            hi = neg_r ? -rem_raw : rem_raw;
            lo = neg_q ? -quo_raw : quo_raw;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one radix-2 step per cycle, stalls the pipe while busy.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned W  = W_DEFAULT,
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    muldiv_sequencer_if.slave bus
);

    state_e         state;
    state_e         state_nxt;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opd;
    opclass_e       cls;
    logic           neg_q;
    logic           neg_r;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;

    logic           sgn_op;
    logic           iter_start;
    logic           step_last;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic           rem_ge;
    logic [W-1:0]   rem_sub;
    logic [2*W-1:0] acc_step;
    logic [W-1:0]   fix_hi;
    logic [W-1:0]   fix_lo;

    always_comb begin
        sgn_op     = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        mag_a      = (sgn_op && bus.srcA[W-1]) ? -bus.srcA : bus.srcA;
        mag_b      = (sgn_op && bus.srcB[W-1]) ? -bus.srcB : bus.srcB;
        iter_start = bus.start && is_iter(bus.op);
        step_last  = (cnt == CW'(W - 1));
    end

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
    always_comb begin
        mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opd} : '0);
        rem_sh  = acc[2*W-1:W-1];
        rem_ge  = (rem_sh >= {1'b0, opd});
        rem_sub = rem_sh[W-1:0] - opd;
        if (cls == CLS_DIV) begin
            acc_step = rem_ge ? {rem_sub, acc[W-2:0], 1'b1}
                              : {rem_sh[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[W-1:1]};
        end
    end

    muldiv_sequencer_sign_fix #(.W(W)) u_sign_fix (
        .raw   (acc),
        .cls   (cls),
        .neg_q (neg_q),
        .neg_r (neg_r),
        .hi    (fix_hi),
        .lo    (fix_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (iter_start) state_nxt = S_RUN;
            S_RUN:   if (step_last)  state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        bus.busy  = (state != S_IDLE);
        bus.done  = (state == S_FIX);
        bus.stall = bus.busy && (bus.start || bus.rd_req);
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            acc   <= '0;
            opd   <= '0;
            cls   <= CLS_MUL;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iter_start) begin
                        cnt   <= '0;
                        cls   <= bus.op[1] ? CLS_DIV : CLS_MUL;
                        opd   <= bus.op[1] ? mag_b : mag_a;
                        acc   <= {{W{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                        // A zero divisor leaves the all-ones quotient unnegated.
                        neg_q <= sgn_op && (bus.srcA[W-1] ^ bus.srcB[W-1])
                                 && !(bus.op[1] && (bus.srcB == '0));
                        neg_r <= sgn_op && bus.op[1] && bus.srcA[W-1];
                    end else if (bus.start && (bus.op == OP_MTHI)) begin
                        hi_q <= bus.srcA;
                    end else if (bus.start && (bus.op == OP_MTLO)) begin
                        lo_q <= bus.srcA;
                    end
                end
                S_RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random ops, and hand-built stall/reset/MT sequences.
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;

    logic clk;
    logic reset;

    muldiv_sequencer_if #(.W(W)) bus ();

    muldiv_sequencer #(.W(W), .CW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [63:0] sb_q[$];
    logic        done_d = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        logic [63:0] res;
        if (op == 3'b000 || op == 3'b010) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'b0, a};
            sb = {32'b0, b};
        end
        if (op[1] == 1'b0) begin
            res = sa * sb;
        end else if (b == 32'b0) begin
            res = {a, 32'hFFFF_FFFF};
        end else begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    always @(posedge clk) done_d <= bus.done && !reset;

    always @(negedge clk) begin
        if (done_d) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 64'd1, 64'd0);
            end else begin
                chk("result_hilo", {bus.hi, bus.lo}, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int unsigned n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.srcA  = a;
        bus.srcB  = b;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        n = 1;
        while (!bus.done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_cycle", 64'(n), 64'd33);
        @(posedge clk); #1;
        chk("busy_after_done", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int unsigned n;
        int unsigned stall_cnt;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0]  = '{3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tbl[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2]  = '{3'b011, 32'd100,       32'd7,         32'd2,         32'd14};
        tbl[3]  = '{3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[4]  = '{3'b010, 32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF};
        tbl[5]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        tbl[6]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        tbl[7]  = '{3'b011, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
        tbl[8]  = '{3'b001, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780};
        tbl[9]  = '{3'b010, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF};
        tbl[10] = '{3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        tbl[11] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};
        tbl[12] = '{3'b011, 32'd5,         32'd10,        32'd5,         32'd0};

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.srcA   = '0;
        bus.srcB   = '0;
        bus.rd_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy",  64'(bus.busy),  64'd0);
        chk("reset_done",  64'(bus.done),  64'd0);
        chk("reset_stall", 64'(bus.stall), 64'd0);
        chk("reset_hilo",  {bus.hi, bus.lo}, 64'd0);

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo});
        end

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            run_op(rop, ra, rb, model(rop, ra, rb));
        end

        // rd_req held through an op, with a second start pulsed mid-RUN and then withdrawn.
        bus.start = 1'b1; bus.op = 3'b000; bus.srcA = 32'hFFFF_FFFD; bus.srcB = 32'd5;
        sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.rd_req = 1'b1;
        stall_cnt  = 0;
        for (int c = 1; c <= 33; c++) begin
            if (c == 5) begin
                bus.start = 1'b1; bus.op = 3'b011; bus.srcA = 32'd50; bus.srcB = 32'd5;
            end
            if (c == 9) bus.start = 1'b0;
            #1;
            if (bus.stall) stall_cnt++;
            @(posedge clk); #1;
        end
        #1;
        chk("rd_stall_cycles", 64'(stall_cnt), 64'd33);
        chk("rd_stall_release", 64'(bus.stall), 64'd0);
        chk("rd_busy_release", 64'(bus.busy), 64'd0);
        bus.rd_req = 1'b0;
        @(posedge clk); #1;
        chk("no_restart_busy", 64'(bus.busy), 64'd0);

        // Synchronous reset in RUN cycle 10 aborts the op and clears HI/LO.
        bus.start = 1'b1; bus.op = 3'b000; bus.srcA = 32'd7; bus.srcB = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midop_reset_busy", 64'(bus.busy), 64'd0);
        chk("midop_reset_done", 64'(bus.done), 64'd0);
        chk("midop_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk); #1;
        chk("midop_reset_idle", 64'(bus.busy), 64'd0);
        run_op(3'b000, 32'd2, 32'd3, 64'd6);

        // MTLO in IDLE: single-edge write, no busy/stall.
        bus.start = 1'b1; bus.op = 3'b101; bus.srcA = 32'h1234; bus.srcB = '0;
        #1;
        chk("mtlo_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'h1234);
        chk("mtlo_hi_kept", 64'(bus.hi), 64'd0);
        chk("mtlo_busy", 64'(bus.busy), 64'd0);

        // Reserved ops 110/111 change nothing.
        for (int k = 6; k <= 7; k++) begin
            bus.start = 1'b1; bus.op = 3'(k); bus.srcA = 32'hDEAD; bus.srcB = 32'hBEEF;
            @(posedge clk); #1;
            bus.start = 1'b0;
            chk("resv_busy", 64'(bus.busy), 64'd0);
            chk("resv_hilo", {bus.hi, bus.lo}, {32'd0, 32'h1234});
        end

        // MTHI requested during busy is held off until the op completes.
        bus.start = 1'b1; bus.op = 3'b000; bus.srcA = 32'd2; bus.srcB = 32'd3;
        sb_q.push_back(64'd6);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 3'b100; bus.srcA = 32'hABCD; bus.srcB = '0;
        #1;
        n = 3;
        stall_cnt = 0;
        while (bus.busy && n < 100) begin
            if (bus.stall) stall_cnt++;
            @(posedge clk); #1;
            n++;
        end
        chk("mthi_stall_cycles", 64'(stall_cnt), 64'd31);
        chk("mthi_accept_cycle", 64'(n), 64'd34);
        chk("mthi_stall_release", 64'(bus.stall), 64'd0);
        chk("mthi_hi_before", 64'(bus.hi), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("mthi_hi_after", 64'(bus.hi), 64'hABCD);
        chk("mthi_lo_kept", 64'(bus.lo), 64'd6);
        chk("mthi_busy", 64'(bus.busy), 64'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
